// File: rtl/led_breathe_pwm_pkg.sv
// Shared constants for the LED breathing block: FSM phase codes and LFOSC divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_breathe_pwm_pkg;

    // Pattern FSM phase encoding, also exported on the phase port
    localparam logic [1:0] PHASE_UP      = 2'd0;
    localparam logic [1:0] PHASE_HOLD_HI = 2'd1;
    localparam logic [1:0] PHASE_DOWN    = 2'd2;
    localparam logic [1:0] PHASE_HOLD_LO = 2'd3;

    // LFOSC frequency and the 1 Hz divide ratio used by the upstream tick divider
    localparam int unsigned LFOSC_HZ      = 32768;
    localparam int unsigned LFOSC_1HZ_DIV = LFOSC_HZ;

    // Bits needed to count 0..n-1, never less than one
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_breathe_pwm_gen.sv
// PWM generator: free-running counter, duty latched at counter wrap, registered compare.
// Latency: pwm_out reflects duty one period after duty_in is sampled at the wrap edge.
// Backpressure: none; enable=0 freezes counter and duty and forces pwm_out low.
module pwm_gen
    import led_breathe_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] duty_in,
    output logic                pwm_out
);

    localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_duty_eff;
    logic                r_led;

    // Counter, wrap-synchronous duty latch and LED compare; all frozen while disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt  <= '0;
            r_duty_eff <= '0;
            r_led      <= 1'b0;
        end else if (enable) begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            // Only change duty between periods so a period never mixes two duties
            if (r_pwm_cnt == MAX) begin
                r_duty_eff <= duty_in;
            end
            r_led <= (r_pwm_cnt < r_duty_eff);
        end else begin
            r_led <= 1'b0;
        end
    end

    assign pwm_out = r_led;

endmodule

// File: rtl/led_breathe_pwm.sv
// LED breathing pattern: tick-driven ramp up / hold / ramp down / hold into a PWM duty.
// Latency: level/phase update on the tick edge; led follows after the next PWM wrap.
// Backpressure: none; ticks while enable=0 are dropped. Gamma map: LED_BREATHE_GAMMA_EN.
module led_breathe_pwm
    import led_breathe_pwm_pkg::*;
#(
    parameter int PWM_BITS   = 8,
    parameter int STEP       = 4,
    parameter int HOLD_TICKS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                tick,
    output logic                led,
    output logic [PWM_BITS-1:0] level,
    output logic [1:0]          phase
);

    localparam int unsigned         HCW       = cnt_width(HOLD_TICKS);
    localparam logic [HCW-1:0]      HOLD_LAST = HCW'(HOLD_TICKS - 1);
    localparam logic [PWM_BITS-1:0] MAX       = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS:0]   MAX_W     = {1'b0, MAX};
    localparam logic [PWM_BITS:0]   STEP_W    = (PWM_BITS+1)'(STEP);
    localparam logic [PWM_BITS-1:0] STEP_N    = PWM_BITS'(STEP);

    logic [PWM_BITS-1:0] r_level;
    logic [1:0]          r_phase;
    logic [HCW-1:0]      r_hold_cnt;
    logic [PWM_BITS:0]   w_level_ext;
    logic [PWM_BITS-1:0] w_duty;

    // One spare bit so the saturation compares cannot wrap
    assign w_level_ext = {1'b0, r_level};

    // Pattern FSM: advances only on an enabled tick, saturating at 0 and MAX
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase    <= PHASE_UP;
            r_level    <= '0;
            r_hold_cnt <= '0;
        end else if (enable && tick) begin
            case (r_phase)
                PHASE_UP: begin
                    if (w_level_ext > (MAX_W - STEP_W)) begin
                        r_level    <= MAX;
                        r_hold_cnt <= '0;
                        r_phase    <= PHASE_HOLD_HI;
                    end else begin
                        r_level <= r_level + STEP_N;
                    end
                end
                PHASE_HOLD_HI: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_hold_cnt <= '0;
                        r_phase    <= PHASE_DOWN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                PHASE_DOWN: begin
                    if (w_level_ext < STEP_W) begin
                        r_level    <= '0;
                        r_hold_cnt <= '0;
                        r_phase    <= PHASE_HOLD_LO;
                    end else begin
                        r_level <= r_level - STEP_N;
                    end
                end
                default: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_hold_cnt <= '0;
                        r_phase    <= PHASE_UP;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef LED_BREATHE_GAMMA_EN
    // Perceptual map: level squared, keep the top half of the product
    logic [2*PWM_BITS-1:0] w_sq;
    assign w_sq   = {{PWM_BITS{1'b0}}, r_level} * {{PWM_BITS{1'b0}}, r_level};
    assign w_duty = w_sq[2*PWM_BITS-1:PWM_BITS];
`else
    // Linear map: the level is the duty
    assign w_duty = r_level;
`endif

    pwm_gen #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_gen (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .duty_in (w_duty),
        .pwm_out (led)
    );

    assign level = r_level;
    assign phase = r_phase;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Bench for led_breathe_pwm at PWM_BITS=4, STEP=4, HOLD_TICKS=2.
// Stimulus pushes expected values into a scoreboard; a negedge monitor pops and compares.
// The monitor also keeps a 16-sample led window to count high clocks per period.
module tb_led_breathe_pwm;

    localparam int PB = 4;

`ifdef LED_BREATHE_GAMMA_EN
    localparam int H4  = 1;
    localparam int H8  = 4;
    localparam int H12 = 9;
`else
    localparam int H4  = 4;
    localparam int H8  = 8;
    localparam int H12 = 12;
`endif

    localparam int K_LEVEL = 0;
    localparam int K_PHASE = 1;
    localparam int K_LED   = 2;
    localparam int K_HIGHS = 3;

    typedef struct {
        int    kind;
        int    val;
        string name;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic          tick = 1'b1;
    logic          led;
    logic [PB-1:0] level;
    logic [1:0]    phase;

    exp_t     sb[$];
    int       n_chk = 0;
    int       n_bad = 0;
    int       ecnt = 0;
    logic [15:0] win = '0;
    exp_t     e;
    int       act;

    int ramp_lvl[12] = '{4, 8, 12, 15, 15, 15, 11, 7, 3, 0, 0, 0};
    int ramp_ph[12]  = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 0};

    led_breathe_pwm #(
        .PWM_BITS   (PB),
        .STEP       (4),
        .HOLD_TICKS (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick),
        .led    (led),
        .level  (level),
        .phase  (phase)
    );

    always #5 clk = ~clk;

    // Monitor: sample led into the window, then settle every pending expectation
    always @(negedge clk) begin
        win = {win[14:0], led};
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_LEVEL: act = int'(level);
                K_PHASE: act = int'(phase);
                K_LED:   act = int'(led);
                default: act = $countones(win);
            endcase
            n_chk++;
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s: got %0d expected %0d", e.name, act, e.val);
            end
        end
    end

    task automatic expect_v(input int kind, input int val, input string name);
        exp_t x;
        x.kind = kind;
        x.val  = val;
        x.name = name;
        sb.push_back(x);
    endtask

    // One clock; tracks the PWM counter position from the inputs applied at the edge
    task automatic clk1();
        logic r_rst;
        logic r_en;
        r_rst = reset;
        r_en  = enable;
        @(posedge clk);
        #1;
        if (r_rst)      ecnt = 0;
        else if (r_en)  ecnt++;
    endtask

    task automatic step_to(input int k);
        for (int i = 0; i < 16 && (ecnt % 16) != k; i++) clk1();
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        clk1();
        tick = 1'b0;
    endtask

    // Wait past the next wrap so the current level is latched, then check one full period
    task automatic measure(input int exp_highs, input string name);
        clk1();
        step_to(0);
        repeat (16) clk1();
        expect_v(K_HIGHS, exp_highs, name);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk1();
        reset = 1'b0;
    endtask

    initial begin
        // Reset held three clocks with tick and enable high
        for (int i = 0; i < 3; i++) begin
            clk1();
            expect_v(K_LED,   0, "rst_led");
            expect_v(K_LEVEL, 0, "rst_level");
            expect_v(K_PHASE, 0, "rst_phase");
        end
        reset = 1'b0;
        tick  = 1'b0;

        // Full breathing cycle, one tick every 20 clocks
        for (int t = 0; t < 12; t++) begin
            pulse_tick();
            expect_v(K_LEVEL, ramp_lvl[t], "ramp_level");
            expect_v(K_PHASE, ramp_ph[t],  "ramp_phase");
            repeat (19) clk1();
        end

        // PWM duty at level 0 and level 8
        do_reset();
        measure(0, "pwm_l0");
        pulse_tick();
        pulse_tick();
        expect_v(K_LEVEL, 8, "pwm_set8");
        measure(H8, "pwm_l8");

        // Tick on the wrap edge: old duty for one period, new duty the next
        do_reset();
        pulse_tick();
        expect_v(K_LEVEL, 4, "sync_l4");
        clk1();
        step_to(0);
        step_to(15);
        pulse_tick();
        expect_v(K_LEVEL, 8, "sync_l8");
        repeat (16) clk1();
        expect_v(K_HIGHS, H4, "sync_p1");
        repeat (16) clk1();
        expect_v(K_HIGHS, H8, "sync_p2");

        // Enable drop mid-ramp: led off next edge, ticks ignored, resume afterwards
        do_reset();
        pulse_tick();
        pulse_tick();
        clk1();
        step_to(0);
        step_to(2);
        expect_v(K_LED, 1, "en_led_before");
        enable = 1'b0;
        clk1();
        expect_v(K_LED,   0, "en_led_off");
        expect_v(K_LEVEL, 8, "en_level_hold");
        for (int i = 0; i < 49; i++) begin
            tick = ((i % 10) == 5);
            clk1();
            if ((i % 10) == 6) begin
                expect_v(K_LED,   0, "en_led_frozen");
                expect_v(K_LEVEL, 8, "en_level_frozen");
                expect_v(K_PHASE, 0, "en_phase_frozen");
            end
        end
        tick   = 1'b0;
        enable = 1'b1;
        clk1();
        pulse_tick();
        expect_v(K_LEVEL, 12, "en_resume");
        measure(H12, "en_pwm_l12");

        // Let the monitor drain, bounded
        for (int i = 0; i < 4 && sb.size() > 0; i++) clk1();
        clk1();
        if (sb.size() != 0) begin
            n_bad += sb.size();
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
